// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline sequencer: state encodings, parameter
// defaults and the per-cycle pipeline control bundle.
package pipe_pkg;

   typedef enum logic [2:0] {
      ST_RUN      = 3'd0,
      ST_FLUSH    = 3'd1,
      ST_MEM_WAIT = 3'd2,
      ST_DRAIN    = 3'd3,
      ST_HALT     = 3'd4
   } state_e;

   localparam int FLUSH_CYCLES_DEF = 1;
   localparam int DRAIN_CYCLES_DEF = 3;
   localparam int CNT_W_DEF        = 16;

   // Wide enough for the largest legal FLUSH/DRAIN length (7).
   localparam int SEQ_CNT_W = 3;
   typedef logic [SEQ_CNT_W-1:0] seq_cnt_t;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic if_id_flush;
      logic id_ex_bubble;
      logic back_en;
   } ctrl_t;

   localparam ctrl_t CTRL_RUN    = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                                     id_ex_bubble: 1'b0, back_en: 1'b1};
   localparam ctrl_t CTRL_STALL  = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                     id_ex_bubble: 1'b1, back_en: 1'b1};
   localparam ctrl_t CTRL_FLUSH  = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
                                     id_ex_bubble: 1'b0, back_en: 1'b1};
   localparam ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                     id_ex_bubble: 1'b0, back_en: 1'b0};

endpackage

// File: rtl/seq_cnt.sv
// Generic down-counter: load has priority over decrement, decrement stops at
// zero. zero_o marks the cycle whose decrement brings the count to zero.
module seq_cnt
   import pipe_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_i,
   input  logic [SEQ_CNT_W-1:0] load_val_i,
   input  logic                 dec_i,
   output logic                 zero_o
);

   seq_cnt_t cnt_q, cnt_d;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && cnt_q != '0) begin
         cnt_d = cnt_q - seq_cnt_t'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q <= seq_cnt_t'(1));

endmodule

// File: rtl/pipe_sequencer.sv
// Pipeline control sequencer: stalls, flushes, memory waits and halt/drain.
// Define PIPE_SEQ_STATS_EN to build the saturating stall/flush statistics counters.
module pipe_sequencer
   import pipe_pkg::*;
#(
   parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
   parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
   parameter int CNT_W        = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_use_hz,
   input  logic             redirect,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   input  logic             halt_req,
   input  logic             resume,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic             back_en,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   state_e state_q, state_d;
   state_e saved_q, saved_d;
   state_e eff_state;
   ctrl_t  ctrl;

   logic flush_load, flush_dec, flush_zero;
   logic drain_load, drain_dec, drain_zero;

   seq_cnt u_flush_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (flush_load),
      .load_val_i (seq_cnt_t'(FLUSH_CYCLES - 1)),
      .dec_i      (flush_dec),
      .zero_o     (flush_zero)
   );

   seq_cnt u_drain_cnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (drain_load),
      .load_val_i (seq_cnt_t'(DRAIN_CYCLES)),
      .dec_i      (drain_dec),
      .zero_o     (drain_zero)
   );

   always_comb begin
      state_d    = state_q;
      saved_d    = saved_q;
      ctrl       = CTRL_FREEZE;
      flush_load = 1'b0;
      flush_dec  = 1'b0;
      drain_load = 1'b0;
      drain_dec  = 1'b0;
      // Once memory is ready again, MEM_WAIT behaves exactly like the state it interrupted.
      eff_state  = (state_q == ST_MEM_WAIT) ? saved_q : state_q;

      if (state_q == ST_HALT) begin
         if (resume) state_d = ST_RUN;
      end else if (!dmem_ready) begin
         state_d = ST_MEM_WAIT;
         if (state_q != ST_MEM_WAIT) saved_d = state_q;
      end else begin
         state_d = eff_state;
         case (eff_state)
            ST_RUN: begin
               if (load_use_hz) begin
                  ctrl = CTRL_STALL;
               end else if (redirect) begin
                  ctrl = CTRL_FLUSH;
                  if (FLUSH_CYCLES > 1) begin
                     state_d    = ST_FLUSH;
                     flush_load = 1'b1;
                  end
               end else if (!imem_ready) begin
                  ctrl = CTRL_STALL;
               end else if (halt_req) begin
                  ctrl       = CTRL_RUN;
                  state_d    = ST_DRAIN;
                  drain_load = 1'b1;
               end else begin
                  ctrl = CTRL_RUN;
               end
            end
            ST_FLUSH: begin
               if (load_use_hz) begin
                  ctrl = CTRL_STALL;
               end else if (redirect) begin
                  ctrl       = CTRL_FLUSH;
                  flush_load = 1'b1;
               end else begin
                  ctrl      = CTRL_FLUSH;
                  flush_dec = 1'b1;
                  if (flush_zero) state_d = ST_RUN;
               end
            end
            ST_DRAIN: begin
               ctrl      = CTRL_STALL;
               drain_dec = 1'b1;
               if (drain_zero) state_d = ST_HALT;
            end
            default: begin
               ctrl    = CTRL_RUN;
               state_d = ST_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         saved_q <= ST_RUN;
      end else begin
         state_q <= state_d;
         saved_q <= saved_d;
      end
   end

   assign pc_en        = ctrl.pc_en;
   assign if_id_en     = ctrl.if_id_en;
   assign if_id_flush  = ctrl.if_id_flush;
   assign id_ex_bubble = ctrl.id_ex_bubble;
   assign back_en      = ctrl.back_en;
   assign state_o      = state_q;

`ifdef PIPE_SEQ_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!ctrl.pc_en && state_q != ST_HALT && stall_cnt_q != '1)
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (ctrl.if_id_flush && flush_cnt_q != '1)
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
